// File: rtl/lib_arbiter_pkg.sv
// Shared types and defaults for the pixel-group enable arbiter.
// Linear group index is idx = row*cols + col.
package lib_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  localparam int GRP_ROWS_DEF = 8;
  localparam int GRP_COLS_DEF = 8;
  localparam int GRP_ADD_DEF  = 3;
  localparam int TIMEOUT_DEF  = 255;

  function automatic void idx_to_rowcol(input int idx, input int cols,
                                        output int row, output int col);
    row = idx / cols;
    col = idx % cols;
  endfunction

endpackage

// File: rtl/rr_find_first.sv
// Round-robin first-set search: the request vector is doubled so that a
// single low-to-high priority scan starting at ptr naturally wraps.
module rr_find_first #(
  parameter int N  = 64,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [2*N-1:0] masked;
  logic [IW:0]    pos;

  always_comb begin
    masked = '0;
    for (int j = 0; j < 2*N; j++) begin
      masked[j] = (j >= int'(ptr)) ? req[j % N] : 1'b0;
    end
  end

  // Scan high-to-low so the lowest set bit at or above ptr wins.
  always_comb begin
    pos = '0;
    for (int j = 2*N-1; j >= 0; j--) begin
      if (masked[j]) pos = (IW+1)'(j);
    end
  end

  assign found = |req;
  assign idx   = (pos >= (IW+1)'(N)) ? IW'(pos - (IW+1)'(N)) : IW'(pos);

endmodule

// File: rtl/group_enable_ctrl.sv
// Upper-level responder: grants one pixel group at a time round-robin,
// holds the grant until release or watchdog expiry, then inserts one gap cycle.
module group_enable_ctrl
  import lib_arbiter_pkg::*;
#(
  parameter int GRP_ROWS = GRP_ROWS_DEF,
  parameter int GRP_COLS = GRP_COLS_DEF,
  parameter int GRP_ADD  = GRP_ADD_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [GRP_ROWS-1:0][GRP_COLS-1:0]  req_i,
  input  logic                               grp_release_i,
  output logic [GRP_ROWS-1:0][GRP_COLS-1:0]  enable_o,
  output logic [GRP_ADD-1:0]                 x_add_o,
  output logic [GRP_ADD-1:0]                 y_add_o,
  output logic                               active_o,
  output logic                               timeout_o
);

  localparam int N  = GRP_ROWS * GRP_COLS;
  localparam int IW = $clog2(N);
  localparam logic [15:0] WD_MAX = 16'(TIMEOUT);

  state_t          state;
  logic [N-1:0]    req_flat;
  logic [N-1:0]    en;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   cur;
  logic [IW-1:0]   win;
  logic            found;
  logic [15:0]     wd;
  logic [GRP_ADD-1:0] win_x;
  logic [GRP_ADD-1:0] win_y;

  assign req_flat = req_i;
  assign enable_o = en;

  rr_find_first #(.N(N), .IW(IW)) u_find (
    .req   (req_flat),
    .ptr   (ptr),
    .found (found),
    .idx   (win)
  );

  always_comb begin
    int r, c;
    idx_to_rowcol(int'(win), GRP_COLS, r, c);
    win_y = GRP_ADD'(r);
    win_x = GRP_ADD'(c);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state     <= IDLE;
      en        <= '0;
      x_add_o   <= '0;
      y_add_o   <= '0;
      active_o  <= 1'b0;
      timeout_o <= 1'b0;
      ptr       <= '0;
      cur       <= '0;
      wd        <= '0;
    end else begin
      timeout_o <= 1'b0;
      case (state)
        IDLE: if (found) begin
          state    <= HOLD;
          en       <= N'(1) << win;
          x_add_o  <= win_x;
          y_add_o  <= win_y;
          active_o <= 1'b1;
          cur      <= win;
          wd       <= '0;
        end
        HOLD: begin
          // Release takes precedence; timeout flag only when the watchdog alone fired.
          if (grp_release_i || wd == WD_MAX) begin
            state     <= GAP;
            en        <= '0;
            active_o  <= 1'b0;
            timeout_o <= !grp_release_i;
            ptr       <= (cur == IW'(N-1)) ? '0 : cur + 1'b1;
          end else begin
            wd <= wd + 16'd1;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_group_enable_ctrl.sv
// Directed bench for group_enable_ctrl with an 8x8 matrix and TIMEOUT=4.
module tb_group_enable_ctrl;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [7:0][7:0]  req;
  logic             rel;
  logic [7:0][7:0]  enable;
  logic [2:0]       x_add, y_add;
  logic             active, timeout;
  logic [63:0]      en_flat;

  int total = 0;
  int bad   = 0;

  assign en_flat = enable;

  group_enable_ctrl #(.GRP_ROWS(8), .GRP_COLS(8), .GRP_ADD(3), .TIMEOUT(4)) dut (
    .clk_i         (clk),
    .reset_i       (reset_n),
    .req_i         (req),
    .grp_release_i (rel),
    .enable_o      (enable),
    .x_add_o       (x_add),
    .y_add_o       (y_add),
    .active_o      (active),
    .timeout_o     (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_grant(input string tag, input int idx);
    chk({tag, "_en"}, en_flat, 64'd1 << idx);
    chk({tag, "_y"}, 64'(y_add), 64'(idx / 8));
    chk({tag, "_x"}, 64'(x_add), 64'(idx % 8));
    chk({tag, "_act"}, 64'(active), 64'd1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_en"}, en_flat, 64'd0);
    chk({tag, "_act"}, 64'(active), 64'd0);
    chk({tag, "_to"}, 64'(timeout), 64'd0);
  endtask

  // Structural invariants every cycle once out of reset.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      chk("onehot", 64'($countones(en_flat) <= 1), 64'd1);
      chk("act_eq_en", 64'(active), 64'(|en_flat));
    end
  end

  initial begin
    int rr_exp[4];
    rr_exp = '{0, 5, 63, 0};
    reset_n = 1'b0;
    req     = '0;
    rel     = 1'b0;
    tick(); tick();
    chk_idle("rst");
    chk("rst_x", 64'(x_add), 64'd0);
    chk("rst_y", 64'(y_add), 64'd0);
    reset_n = 1'b1;

    // Single request: grant next edge, release, GAP, IDLE, re-grant.
    req[2][3] = 1'b1;
    tick();
    chk_grant("single", 19);
    tick(); tick();
    chk_grant("single_hold", 19);
    rel = 1'b1;
    tick();
    rel = 1'b0;
    chk_idle("single_gap");
    chk("gap_keep_x", 64'(x_add), 64'd3);
    chk("gap_keep_y", 64'(y_add), 64'd2);
    tick();
    chk_idle("single_idle");
    tick();
    chk_grant("single_regrant", 19);
    rel = 1'b1;
    tick();
    rel = 1'b0;
    req = '0;
    tick(); tick();                        // pointer now 20

    // Timeout: [1][1] wins by wrap; a late request on [6][0] must not disturb HOLD.
    req[1][1] = 1'b1;
    tick();
    chk_grant("to_grant", 9);
    req[6][0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_grant("to_hold", 9);
      chk("to_hold_to", 64'(timeout), 64'd0);
    end
    tick();
    chk("to_fire_en", en_flat, 64'd0);
    chk("to_fire_to", 64'(timeout), 64'd1);
    tick();
    chk("to_pulse_end", 64'(timeout), 64'd0);
    tick();
    chk_grant("to_ptr10", 48);             // pointer 10 skips idx 9

    // Release coinciding with watchdog expiry counts as release.
    for (int i = 0; i < 4; i++) tick();
    rel = 1'b1;
    tick();
    rel = 1'b0;
    chk_idle("simul");
    req = '0;
    tick(); tick();                        // pointer now 49

    // Reset mid-HOLD; the next search restarts from idx 0.
    req[2][3] = 1'b1;
    tick();
    chk_grant("rh_grant", 19);
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk_idle("rh_rst");
    chk("rh_x", 64'(x_add), 64'd0);
    chk("rh_y", 64'(y_add), 64'd0);
    req = '0;
    req[0][1] = 1'b1;
    req[7][7] = 1'b1;
    tick();
    chk_grant("rh_from0", 1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    req = '0;

    // Round-robin across three persistent requesters with wrap.
    req[0][0] = 1'b1;
    req[0][5] = 1'b1;
    req[7][7] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_grant("rr", rr_exp[k]);
      tick();
      rel = 1'b1;
      tick();
      rel = 1'b0;
      chk_idle("rr_gap");
      tick();
    end
    req = '0;
    tick(); tick();

    // Stray release in IDLE and GAP is ignored.
    rel = 1'b1;
    tick();
    chk_idle("stray_idle");
    rel = 1'b0;
    req[2][3] = 1'b1;
    tick();
    chk_grant("stray_grant", 19);
    rel = 1'b1;
    tick();
    req = '0;
    chk_idle("stray_gap0");
    tick();
    chk_idle("stray_gap1");
    tick();
    chk_idle("stray_gap2");
    rel = 1'b0;
    chk("stray_keep_x", 64'(x_add), 64'd3);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
